// File: rtl/disp_pkg.sv
// Shared encodings for the display read arbiter.
// FSM state and one-hot GRANT codes {M1,M0}.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/disp_arb_pick.sv
// Priority pick between M0 and M1, M0 preferred.
// DISP_RD_ARB_STARVE_EN adds a run counter that lets M1 through.
module disp_arb_pick
  import disp_pkg::*;
#(
  parameter int MAX_M0_RUN = 4
) (
`ifdef DISP_RD_ARB_STARVE_EN
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_take,
`endif
  input  logic       i_m0_req,
  input  logic       i_m1_req,
  output logic [1:0] o_pick
);

  if (MAX_M0_RUN < 1 || MAX_M0_RUN > 15) begin : g_bad_run
    $error("MAX_M0_RUN must be 1..15");
  end

`ifdef DISP_RD_ARB_STARVE_EN
  localparam logic [3:0] LP_RUN = 4'(MAX_M0_RUN);

  logic [3:0] r_run;
  logic       w_starve;

  assign w_starve = i_m1_req && (r_run == LP_RUN);

  // M1 wins once M0 has used up its run while M1 waited
  always_comb begin
    o_pick = GNT_NONE;
    if (w_starve)      o_pick = GNT_M1;
    else if (i_m0_req) o_pick = GNT_M0;
    else if (i_m1_req) o_pick = GNT_M1;
  end

  // count M0 grants taken while M1 waits; clear on M1 grant
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run <= '0;
    end else if (i_take) begin
      if (o_pick == GNT_M1)
        r_run <= '0;
      else if (o_pick == GNT_M0 && i_m1_req)
        r_run <= r_run + 4'd1;
    end
  end
`else
  // plain fixed priority
  always_comb begin
    o_pick = GNT_NONE;
    if (i_m0_req)      o_pick = GNT_M0;
    else if (i_m1_req) o_pick = GNT_M1;
  end
`endif

endmodule

// File: rtl/disp_rd_arb.sv
// Two-master AXI read arbiter, one burst in flight downstream.
// Optional starvation guard: define DISP_RD_ARB_STARVE_EN.
module disp_rd_arb
  import disp_pkg::*;
#(
  parameter int DW         = 64,
  parameter int MAX_M0_RUN = 4
) (
  input  logic          ACLK,
  input  logic          ARSTN,
  input  logic [31:0]   M0_ARADDR,
  input  logic [7:0]    M0_ARLEN,
  input  logic          M0_ARVALID,
  output logic          M0_ARREADY,
  output logic [DW-1:0] M0_RDATA,
  output logic          M0_RLAST,
  output logic          M0_RVALID,
  input  logic          M0_RREADY,
  input  logic [31:0]   M1_ARADDR,
  input  logic [7:0]    M1_ARLEN,
  input  logic          M1_ARVALID,
  output logic          M1_ARREADY,
  output logic [DW-1:0] M1_RDATA,
  output logic          M1_RLAST,
  output logic          M1_RVALID,
  input  logic          M1_RREADY,
  output logic [31:0]   S_ARADDR,
  output logic [7:0]    S_ARLEN,
  output logic          S_ARVALID,
  input  logic          S_ARREADY,
  input  logic [DW-1:0] S_RDATA,
  input  logic          S_RLAST,
  input  logic          S_RVALID,
  output logic          S_RREADY,
  output logic [1:0]    GRANT
);

  state_t     r_state, w_state_nxt;
  logic [1:0] r_gnt, w_gnt_nxt, w_pick;
  logic       w_in_addr, w_in_data;
  logic       w_g0, w_g1;

`ifdef DISP_RD_ARB_STARVE_EN
  logic w_take;
  assign w_take = (r_state == IDLE);
`endif

  disp_arb_pick #(
    .MAX_M0_RUN(MAX_M0_RUN)
  ) u_pick (
`ifdef DISP_RD_ARB_STARVE_EN
    .i_clk   (ACLK),
    .i_rst_n (ARSTN),
    .i_take  (w_take),
`endif
    .i_m0_req(M0_ARVALID),
    .i_m1_req(M1_ARVALID),
    .o_pick  (w_pick)
  );

  assign w_in_addr = (r_state == ADDR);
  assign w_in_data = (r_state == DATA);
  assign w_g0      = (r_gnt == GNT_M0);
  assign w_g1      = (r_gnt == GNT_M1);
  assign GRANT     = r_gnt;

  // state and owner registers
  always_ff @(posedge ACLK or negedge ARSTN) begin
    if (!ARSTN) begin
      r_state <= IDLE;
      r_gnt   <= GNT_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  // next state: a burst runs to RLAST before any re-arbitration
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    unique case (r_state)
      IDLE: begin
        if (w_pick != GNT_NONE) begin
          w_state_nxt = ADDR;
          w_gnt_nxt   = w_pick;
        end
      end
      ADDR: begin
        if (S_ARREADY) w_state_nxt = DATA;
      end
      DATA: begin
        if (S_RVALID && S_RREADY && S_RLAST) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = GNT_NONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = GNT_NONE;
      end
    endcase
  end

  // route AR and R channels to/from the owner only
  always_comb begin
    S_ARADDR   = '0;
    S_ARLEN    = '0;
    S_ARVALID  = w_in_addr;
    M0_ARREADY = w_in_addr && w_g0 && S_ARREADY;
    M1_ARREADY = w_in_addr && w_g1 && S_ARREADY;
    unique case (1'b1)
      w_in_addr && w_g0: begin
        S_ARADDR = M0_ARADDR;
        S_ARLEN  = M0_ARLEN;
      end
      w_in_addr && w_g1: begin
        S_ARADDR = M1_ARADDR;
        S_ARLEN  = M1_ARLEN;
      end
      default: ;
    endcase
    S_RREADY  = w_in_data
             && ((w_g0 && M0_RREADY) || (w_g1 && M1_RREADY));
    M0_RVALID = w_in_data && w_g0 && S_RVALID;
    M1_RVALID = w_in_data && w_g1 && S_RVALID;
    M0_RLAST  = w_in_data && w_g0 && S_RLAST;
    M1_RLAST  = w_in_data && w_g1 && S_RLAST;
    M0_RDATA  = (w_in_data && w_g0) ? S_RDATA : '0;
    M1_RDATA  = (w_in_data && w_g1) ? S_RDATA : '0;
  end

endmodule
